keccak_digest_rx: RTL and testbench

//  Receiver for the permutation block's output stream (pushout/firstout/dout, stopout back-pressure).

---
 rtl/keccak_pkg.sv | 22 ++
 rtl/keccak_digest_rx.sv | 116 +++++++++++
 tb/tb_keccak_digest_rx.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/keccak_pkg.sv
// Shared types and helpers for the Keccak digest receive path.
package keccak_pkg;
  localparam int LANE_W = 64;
  localparam int NLANES = 25;

  typedef logic [LANE_W-1:0] lane_t;
  typedef logic [4:0]        lane_idx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    SEND    = 2'd2
  } rx_state_t;

  function automatic lane_t bswap64(input lane_t x);
    lane_t r;
    for (int b = 0; b < 8; b++) begin
      r[8*(7-b) +: 8] = x[8*b +: 8];
    end
    return r;
  endfunction
endpackage

// File: rtl/keccak_digest_rx.sv
// Collects a 25-lane permutation frame, keeps the first DIGEST_LANES lanes and re-emits them as a digest stream.
// Optional build macro KRX_BSWAP_EN byte-reverses each emitted lane (big-endian digest output).
module keccak_digest_rx
  import keccak_pkg::*;
#(
  parameter int DIGEST_LANES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pushin,
  output logic        stopin,
  input  logic        firstin,
  input  logic [63:0] din,
  output logic        pushout,
  input  logic        stopout,
  output logic        firstout,
  output logic        lastout,
  output logic [63:0] dout,
  output logic        err
);

  localparam int TX_W = (DIGEST_LANES > 1) ? $clog2(DIGEST_LANES) : 1;
  localparam logic [TX_W-1:0] TX_LAST   = TX_W'(DIGEST_LANES - 1);
  localparam lane_idx_t       KEEP_N    = lane_idx_t'(DIGEST_LANES);
  localparam lane_idx_t       LAST_LANE = lane_idx_t'(NLANES - 1);

  rx_state_t       state;
  lane_idx_t       rx_idx;
  logic [TX_W-1:0] tx_idx;
  lane_t           dbuf [DIGEST_LANES];
  lane_t           tx_lane;
  logic            accept;

  assign accept  = pushin & ~stopin;
  assign tx_lane = dbuf[tx_idx];

`ifdef KRX_BSWAP_EN
  assign dout = pushout ? bswap64(tx_lane) : '0;
`else
  assign dout = pushout ? tx_lane : '0;
`endif

  // Lane buffer: data only, no reset; a firstin lane always restarts at slot 0.
  always_ff @(posedge clk) begin
    if (accept && state != SEND) begin
      if (firstin) begin
        dbuf[0] <= din;
      end else if (state == COLLECT && rx_idx < KEEP_N) begin
        dbuf[rx_idx[TX_W-1:0]] <= din;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rx_idx   <= '0;
      tx_idx   <= '0;
      stopin   <= 1'b0;
      pushout  <= 1'b0;
      firstout <= 1'b0;
      lastout  <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (firstin) begin
              rx_idx <= lane_idx_t'(1);
              state  <= COLLECT;
            end else begin
              err <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (accept) begin
            if (firstin) begin
              err    <= 1'b1;
              rx_idx <= lane_idx_t'(1);
            end else if (rx_idx == LAST_LANE) begin
              state    <= SEND;
              rx_idx   <= '0;
              tx_idx   <= '0;
              stopin   <= 1'b1;
              pushout  <= 1'b1;
              firstout <= 1'b1;
              lastout  <= (TX_LAST == '0);
            end else begin
              rx_idx <= rx_idx + lane_idx_t'(1);
            end
          end
        end
        SEND: begin
          // Host stall freezes index and markers; dout follows tx_idx so it holds too.
          if (pushout && !stopout) begin
            if (tx_idx == TX_LAST) begin
              state    <= IDLE;
              pushout  <= 1'b0;
              stopin   <= 1'b0;
              firstout <= 1'b0;
              lastout  <= 1'b0;
            end else begin
              tx_idx   <= tx_idx + TX_W'(1);
              firstout <= 1'b0;
              lastout  <= (tx_idx == TX_LAST - TX_W'(1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_digest_rx.sv
// Directed, table-driven bench for keccak_digest_rx (DIGEST_LANES = 4).
module tb_keccak_digest_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        pushin;
  logic        stopin;
  logic        firstin;
  logic [63:0] din;
  logic        pushout;
  logic        stopout;
  logic        firstout;
  logic        lastout;
  logic [63:0] dout;
  logic        err;

  int checks   = 0;
  int failures = 0;

  keccak_digest_rx #(.DIGEST_LANES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .pushin   (pushin),
    .stopin   (stopin),
    .firstin  (firstin),
    .din      (din),
    .pushout  (pushout),
    .stopout  (stopout),
    .firstout (firstout),
    .lastout  (lastout),
    .dout     (dout),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic [63:0] base;
    logic        stall;
    logic        push;
    logic        first;
    logic        last;
    logic [63:0] dat;
    logic        stin;
  } vec_t;

  vec_t vecs [23];

  function automatic logic [63:0] fmt(input logic [63:0] x);
`ifdef KRX_BSWAP_EN
    return {x[7:0], x[15:8], x[23:16], x[31:24], x[39:32], x[47:40], x[55:48], x[63:56]};
`else
    return x;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic drive_lane(input logic [63:0] d, input logic f);
    pushin  = 1'b1;
    firstin = f;
    din     = d;
    step();
  endtask

  task automatic send_frame(input logic [63:0] base, input logic [63:0] lane0);
    for (int i = 0; i < 25; i++) begin
      drive_lane((i == 0) ? lane0 : base + 64'(i), i == 0);
      chk("err_rx", {63'd0, err}, 64'd0);
    end
    pushin  = 1'b0;
    firstin = 1'b0;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      if (vecs[i].start) send_frame(vecs[i].base, vecs[i].base);
      chk($sformatf("pushout[%0d]", i),  {63'd0, pushout},  {63'd0, vecs[i].push});
      chk($sformatf("firstout[%0d]", i), {63'd0, firstout}, {63'd0, vecs[i].first});
      chk($sformatf("lastout[%0d]", i),  {63'd0, lastout},  {63'd0, vecs[i].last});
      chk($sformatf("dout[%0d]", i),     dout,              fmt(vecs[i].dat));
      chk($sformatf("stopin[%0d]", i),   {63'd0, stopin},   {63'd0, vecs[i].stin});
      chk($sformatf("err[%0d]", i),      {63'd0, err},      64'd0);
      stopout = vecs[i].stall;
      step();
    end
    stopout = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    //            start base     stall push first last dat       stin
    // block A: plain frame 0x100
    vecs[0]  = '{1'b1, 64'h100, 1'b0, 1'b1, 1'b1, 1'b0, 64'h100, 1'b1};
    vecs[1]  = '{1'b0, 64'h0,   1'b0, 1'b1, 1'b0, 1'b0, 64'h101, 1'b1};
    vecs[2]  = '{1'b0, 64'h0,   1'b0, 1'b1, 1'b0, 1'b0, 64'h102, 1'b1};
    vecs[3]  = '{1'b0, 64'h0,   1'b0, 1'b1, 1'b0, 1'b1, 64'h103, 1'b1};
    vecs[4]  = '{1'b0, 64'h0,   1'b0, 1'b0, 1'b0, 1'b0, 64'h0,   1'b0};
    // block B: frame 0x100 with a 3-cycle host stall on lane 2
    vecs[5]  = '{1'b1, 64'h100, 1'b0, 1'b1, 1'b1, 1'b0, 64'h100, 1'b1};
    vecs[6]  = '{1'b0, 64'h0,   1'b0, 1'b1, 1'b0, 1'b0, 64'h101, 1'b1};
    vecs[7]  = '{1'b0, 64'h0,   1'b1, 1'b1, 1'b0, 1'b0, 64'h102, 1'b1};
    vecs[8]  = '{1'b0, 64'h0,   1'b1, 1'b1, 1'b0, 1'b0, 64'h102, 1'b1};
    vecs[9]  = '{1'b0, 64'h0,   1'b1, 1'b1, 1'b0, 1'b0, 64'h102, 1'b1};
    vecs[10] = '{1'b0, 64'h0,   1'b0, 1'b1, 1'b0, 1'b0, 64'h102, 1'b1};
    vecs[11] = '{1'b0, 64'h0,   1'b0, 1'b1, 1'b0, 1'b1, 64'h103, 1'b1};
    vecs[12] = '{1'b0, 64'h0,   1'b0, 1'b0, 1'b0, 1'b0, 64'h0,   1'b0};
    // block C: digest of the restarted 0x300 frame (frame sent by hand)
    vecs[13] = '{1'b0, 64'h0,   1'b0, 1'b1, 1'b1, 1'b0, 64'h300, 1'b1};
    vecs[14] = '{1'b0, 64'h0,   1'b0, 1'b1, 1'b0, 1'b0, 64'h301, 1'b1};
    vecs[15] = '{1'b0, 64'h0,   1'b0, 1'b1, 1'b0, 1'b0, 64'h302, 1'b1};
    vecs[16] = '{1'b0, 64'h0,   1'b0, 1'b1, 1'b0, 1'b1, 64'h303, 1'b1};
    vecs[17] = '{1'b0, 64'h0,   1'b0, 1'b0, 1'b0, 1'b0, 64'h0,   1'b0};
    // block D: plain frame 0x500
    vecs[18] = '{1'b1, 64'h500, 1'b0, 1'b1, 1'b1, 1'b0, 64'h500, 1'b1};
    vecs[19] = '{1'b0, 64'h0,   1'b0, 1'b1, 1'b0, 1'b0, 64'h501, 1'b1};
    vecs[20] = '{1'b0, 64'h0,   1'b0, 1'b1, 1'b0, 1'b0, 64'h502, 1'b1};
    vecs[21] = '{1'b0, 64'h0,   1'b0, 1'b1, 1'b0, 1'b1, 64'h503, 1'b1};
    vecs[22] = '{1'b0, 64'h0,   1'b0, 1'b0, 1'b0, 1'b0, 64'h0,   1'b0};

    rst     = 1'b0;
    pushin  = 1'b0;
    firstin = 1'b0;
    din     = '0;
    stopout = 1'b0;

    @(negedge clk);
    @(negedge clk);
    chk("rst_stopin",   {63'd0, stopin},   64'd0);
    chk("rst_pushout",  {63'd0, pushout},  64'd0);
    chk("rst_firstout", {63'd0, firstout}, 64'd0);
    chk("rst_lastout",  {63'd0, lastout},  64'd0);
    chk("rst_dout",     dout,              64'd0);
    chk("rst_err",      {63'd0, err},      64'd0);
    rst = 1'b1;
    step();

    // plain frame, then stalled frame
    run_vecs(0, 4);
    run_vecs(5, 12);

    // stray lane in IDLE
    drive_lane(64'hDEAD, 1'b0);
    chk("stray_err",     {63'd0, err},     64'd1);
    chk("stray_pushout", {63'd0, pushout}, 64'd0);
    pushin = 1'b0;
    step();
    chk("stray_err_pulse", {63'd0, err},     64'd0);
    chk("stray_pushout2",  {63'd0, pushout}, 64'd0);
    run_vecs(18, 22);

    // frame restarted at lane 10
    for (int i = 0; i < 10; i++) begin
      drive_lane(64'h200 + 64'(i), i == 0);
      chk("restart_pre_err", {63'd0, err}, 64'd0);
    end
    drive_lane(64'h300, 1'b1);
    chk("restart_err", {63'd0, err}, 64'd1);
    for (int i = 1; i < 25; i++) begin
      drive_lane(64'h300 + 64'(i), 1'b0);
      chk("restart_post_err", {63'd0, err}, 64'd0);
    end
    pushin = 1'b0;
    run_vecs(13, 17);

    // reset in the middle of SEND
    send_frame(64'h400, 64'h400);
    chk("mid_dout0", dout, fmt(64'h400));
    step();
    chk("mid_dout1", dout, fmt(64'h401));
    step();
    rst = 1'b0;
    #1;
    chk("mid_rst_pushout", {63'd0, pushout}, 64'd0);
    chk("mid_rst_stopin",  {63'd0, stopin},  64'd0);
    chk("mid_rst_err",     {63'd0, err},     64'd0);
    chk("mid_rst_dout",    dout,             64'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    run_vecs(0, 4);

    // lane byte order on output
    send_frame(64'h600, 64'h0011223344556677);
    chk("order_first",   {63'd0, firstout}, 64'd1);
    chk("order_dout",    dout, fmt(64'h0011223344556677));
    step();
    chk("order_dout1",   dout, fmt(64'h601));
    for (int i = 0; i < 3; i++) step();
    chk("order_done",    {63'd0, pushout}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
